// File: rtl/fpu_ss_pkg.sv
// -----------------------------------------------------------------------------
// fpu_ss_pkg
// Shared types for the fpu_ss subsystem and its multi-core issue arbiter:
//   x_issue_req_t / x_issue_resp_t / x_result_t : X-interface payloads
//   fpu_ss_arb_state_e                          : issue arbiter FSM states
//   arb_cnt_width()                             : outstanding counter width
// -----------------------------------------------------------------------------
package fpu_ss_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  id;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic loadstore;
  } x_issue_resp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } x_result_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } fpu_ss_arb_state_e;

  // Bits needed to hold the values 0..max_outstanding inclusive.
  function automatic int unsigned arb_cnt_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 32'd1);
  endfunction

endpackage

// File: rtl/fpu_ss_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_ss_rr_arbiter
// Purely combinational round-robin pick: returns the first requesting index
// at or after ptr, wrapping modulo NB_CORES.
//   req       in  NB_CORES  request vector
//   ptr       in  IDX_W     highest-priority index
//   gnt_idx   out IDX_W     picked index (0 when nothing requests)
//   gnt_valid out 1         at least one request present
// -----------------------------------------------------------------------------
module fpu_ss_rr_arbiter #(
  parameter int unsigned NB_CORES = 8,
  parameter int unsigned IDX_W    = $clog2(NB_CORES)
) (
  input  logic [NB_CORES-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [IDX_W-1:0]    gnt_idx,
  output logic                gnt_valid
);

  // Scan NB_CORES candidates starting at ptr; the first hit wins.
  always_comb begin
    int unsigned cand;
    logic        hit;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 32'd0;
    hit       = 1'b0;
    for (int unsigned k = 0; k < NB_CORES; k++) begin
      cand      = (32'(ptr) + k) % NB_CORES;
      hit       = req[IDX_W'(cand)] & ~gnt_valid;
      gnt_idx   = hit ? IDX_W'(cand) : gnt_idx;
      gnt_valid = gnt_valid | hit;
    end
  end

endmodule

// File: rtl/fpu_ss_issue_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_ss_issue_arbiter
// Shares one fpu_ss among NB_CORES cores. Round-robin arbitrates per-core
// X-interface issue requests onto the single fpu_ss issue port (holding the
// grant while fpu_ss stalls), tracks per-core outstanding instructions and
// routes fpu_ss results back to the owning core.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   core_issue_*                 per-core issue valid/ready/req/resp
//   fpu_issue_*, fpu_core_id_o   issue port toward fpu_ss + granted core index
//   fpu_result_*, fpu_dest_core_id_i  result port from fpu_ss
//   core_result_*                per-core result valid/ready, broadcast payload
//   outstanding_o                per-core accepted-but-not-returned counts
//   err_o                        sticky protocol error (cleared by reset only)
//   perf_stall_o                 per-core stall cycle counters, present only
//                                when FPU_SS_ARB_PERF_EN is defined
// -----------------------------------------------------------------------------
module fpu_ss_issue_arbiter
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NB_CORES        = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = arb_cnt_width(MAX_OUTSTANDING)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic          [NB_CORES-1:0]        core_issue_valid_i,
  output logic          [NB_CORES-1:0]        core_issue_ready_o,
  input  x_issue_req_t  [NB_CORES-1:0]        core_issue_req_i,
  output x_issue_resp_t [NB_CORES-1:0]        core_issue_resp_o,
  output logic                                fpu_issue_valid_o,
  input  logic                                fpu_issue_ready_i,
  output x_issue_req_t                        fpu_issue_req_o,
  input  x_issue_resp_t                       fpu_issue_resp_i,
  output logic          [31:0]                fpu_core_id_o,
  input  logic                                fpu_result_valid_i,
  output logic                                fpu_result_ready_o,
  input  x_result_t                           fpu_result_i,
  input  logic          [31:0]                fpu_dest_core_id_i,
  output logic          [NB_CORES-1:0]        core_result_valid_o,
  input  logic          [NB_CORES-1:0]        core_result_ready_i,
  output x_result_t     [NB_CORES-1:0]        core_result_o,
  output logic          [NB_CORES-1:0][CNT_W-1:0] outstanding_o,
  output logic                                err_o
`ifdef FPU_SS_ARB_PERF_EN
  ,
  output logic          [NB_CORES-1:0][31:0]  perf_stall_o
`endif
);

  localparam int unsigned IDX_W = $clog2(NB_CORES);

  fpu_ss_arb_state_e  state_r, state_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [IDX_W-1:0]   lock_idx_r, lock_idx_nxt_s;
  logic [CNT_W-1:0]   cnt_r [NB_CORES];
  logic               err_r;

  logic [NB_CORES-1:0] elig_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_valid_s;
  logic [IDX_W-1:0]    gnt_idx_s;
  logic                gnt_valid_s;
  logic                issue_hs_s;
  logic                proto_err_s;
  logic                dest_ok_s;
  logic [IDX_W-1:0]    dest_idx_s;
  logic                res_hs_s;
  logic                bad_dest_err_s;
  logic [NB_CORES-1:0] inc_s;
  logic [NB_CORES-1:0] dec_s;
  logic [NB_CORES-1:0] underflow_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (32'(idx) == NB_CORES - 32'd1) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  fpu_ss_rr_arbiter #(
    .NB_CORES (NB_CORES),
    .IDX_W    (IDX_W)
  ) u_rr (
    .req       (elig_s),
    .ptr       (rr_ptr_r),
    .gnt_idx   (pick_idx_s),
    .gnt_valid (pick_valid_s)
  );

  // Current grant: fresh round-robin pick in IDLE, pinned core in LOCKED.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = '0;
    if (rst_i) begin
      gnt_valid_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          gnt_idx_s   = pick_idx_s;
          gnt_valid_s = pick_valid_s;
        end
        LOCKED: begin
          // eligibility is not re-evaluated while a grant is held
          gnt_idx_s   = lock_idx_r;
          gnt_valid_s = core_issue_valid_i[lock_idx_r];
        end
        default: begin
          gnt_valid_s = 1'b0;
        end
      endcase
    end
  end

  assign issue_hs_s = gnt_valid_s & fpu_issue_ready_i;

  // Zero-latency forwarding of the granted core onto the fpu_ss issue port.
  always_comb begin
    fpu_issue_valid_o  = gnt_valid_s;
    fpu_issue_req_o    = '0;
    fpu_core_id_o      = 32'd0;
    core_issue_ready_o = '0;
    core_issue_resp_o  = '0;
    if (gnt_valid_s) begin
      fpu_issue_req_o                = core_issue_req_i[gnt_idx_s];
      fpu_core_id_o                  = 32'(gnt_idx_s);
      core_issue_ready_o[gnt_idx_s]  = fpu_issue_ready_i;
      core_issue_resp_o[gnt_idx_s]   = fpu_issue_resp_i;
    end else begin
      fpu_issue_valid_o = 1'b0;
    end
  end

  // Next-state logic for the grant FSM and round-robin pointer.
  always_comb begin
    state_nxt_s    = state_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    lock_idx_nxt_s = lock_idx_r;
    proto_err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (issue_hs_s) begin
          rr_ptr_nxt_s = wrap_inc(gnt_idx_s);
        end else if (gnt_valid_s) begin
          state_nxt_s    = LOCKED;
          lock_idx_nxt_s = gnt_idx_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKED: begin
        if (issue_hs_s) begin
          state_nxt_s  = IDLE;
          rr_ptr_nxt_s = wrap_inc(lock_idx_r);
        end else if (!core_issue_valid_i[lock_idx_r]) begin
          // requester withdrew mid-transaction: release, keep pointer
          state_nxt_s = IDLE;
          proto_err_s = 1'b1;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign dest_ok_s  = (fpu_dest_core_id_i < 32'(NB_CORES));
  assign dest_idx_s = fpu_dest_core_id_i[IDX_W-1:0];

  // Result demux: steer valid/ready by destination; bad destinations are sunk.
  always_comb begin
    core_result_valid_o = '0;
    fpu_result_ready_o  = 1'b0;
    if (rst_i) begin
      fpu_result_ready_o = 1'b0;
    end else if (dest_ok_s) begin
      core_result_valid_o[dest_idx_s] = fpu_result_valid_i;
      fpu_result_ready_o              = core_result_ready_i[dest_idx_s];
    end else begin
      fpu_result_ready_o = 1'b1;
    end
  end

  assign res_hs_s       = fpu_result_valid_i & fpu_result_ready_o;
  assign bad_dest_err_s = res_hs_s & ~dest_ok_s;

  for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_core
    assign elig_s[gi]        = core_issue_valid_i[gi] &&
                               (cnt_r[gi] < CNT_W'(MAX_OUTSTANDING));
    assign inc_s[gi]         = issue_hs_s && fpu_issue_resp_i.accept &&
                               (gnt_idx_s == IDX_W'(gi));
    assign dec_s[gi]         = res_hs_s && dest_ok_s && (dest_idx_s == IDX_W'(gi));
    assign underflow_s[gi]   = dec_s[gi] && !inc_s[gi] && (cnt_r[gi] == CNT_W'(0));
    assign outstanding_o[gi] = cnt_r[gi];
    assign core_result_o[gi] = fpu_result_i;

    // Outstanding counter: +1 on accepted issue, -1 on returned result, floor at 0.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_r[gi] <= CNT_W'(0);
      end else if (inc_s[gi] && !dec_s[gi]) begin
        cnt_r[gi] <= cnt_r[gi] + CNT_W'(1);
      end else if (dec_s[gi] && !inc_s[gi] && (cnt_r[gi] != CNT_W'(0))) begin
        cnt_r[gi] <= cnt_r[gi] - CNT_W'(1);
      end else begin
        cnt_r[gi] <= cnt_r[gi];
      end
    end
  end

  // FSM, pointer, lock index and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      lock_idx_r <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      lock_idx_r <= lock_idx_nxt_s;
      err_r      <= err_r | proto_err_s | bad_dest_err_s | (|underflow_s);
    end
  end

  assign err_o = err_r;

`ifdef FPU_SS_ARB_PERF_EN
  logic [31:0] perf_r [NB_CORES];

  for (genvar pi = 0; pi < NB_CORES; pi++) begin : g_perf
    // Count cycles a core is requesting without completing an issue handshake.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        perf_r[pi] <= 32'd0;
      end else if (core_issue_valid_i[pi] &&
                   !(issue_hs_s && (gnt_idx_s == IDX_W'(pi))) &&
                   (perf_r[pi] != 32'hFFFF_FFFF)) begin
        perf_r[pi] <= perf_r[pi] + 32'd1;
      end else begin
        perf_r[pi] <= perf_r[pi];
      end
    end
    assign perf_stall_o[pi] = perf_r[pi];
  end
`endif

endmodule

// File: tb/tb_fpu_ss_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_ss_issue_arbiter
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_fpu_ss_issue_arbiter;
  import fpu_ss_pkg::*;

  localparam int NB   = 8;
  localparam int MAXO = 4;
  localparam int CW   = 3;

  logic                           clk = 1'b0;
  logic                           rst_i;
  logic          [NB-1:0]         core_issue_valid_i;
  logic          [NB-1:0]         core_issue_ready_o;
  x_issue_req_t  [NB-1:0]         core_issue_req_i;
  x_issue_resp_t [NB-1:0]         core_issue_resp_o;
  logic                           fpu_issue_valid_o;
  logic                           fpu_issue_ready_i;
  x_issue_req_t                   fpu_issue_req_o;
  x_issue_resp_t                  fpu_issue_resp_i;
  logic          [31:0]           fpu_core_id_o;
  logic                           fpu_result_valid_i;
  logic                           fpu_result_ready_o;
  x_result_t                      fpu_result_i;
  logic          [31:0]           fpu_dest_core_id_i;
  logic          [NB-1:0]         core_result_valid_o;
  logic          [NB-1:0]         core_result_ready_i;
  x_result_t     [NB-1:0]         core_result_o;
  logic          [NB-1:0][CW-1:0] outstanding_o;
  logic                           err_o;

  always #5 clk = ~clk;

  fpu_ss_issue_arbiter #(.NB_CORES(NB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .core_issue_valid_i  (core_issue_valid_i),
    .core_issue_ready_o  (core_issue_ready_o),
    .core_issue_req_i    (core_issue_req_i),
    .core_issue_resp_o   (core_issue_resp_o),
    .fpu_issue_valid_o   (fpu_issue_valid_o),
    .fpu_issue_ready_i   (fpu_issue_ready_i),
    .fpu_issue_req_o     (fpu_issue_req_o),
    .fpu_issue_resp_i    (fpu_issue_resp_i),
    .fpu_core_id_o       (fpu_core_id_o),
    .fpu_result_valid_i  (fpu_result_valid_i),
    .fpu_result_ready_o  (fpu_result_ready_o),
    .fpu_result_i        (fpu_result_i),
    .fpu_dest_core_id_i  (fpu_dest_core_id_i),
    .core_result_valid_o (core_result_valid_o),
    .core_result_ready_i (core_result_ready_i),
    .core_result_o       (core_result_o),
    .outstanding_o       (outstanding_o),
    .err_o               (err_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt[NB];
  bit m_locked;
  int m_lock;
  int m_ptr;
  bit m_err;
  bit m_init = 1'b0;

  // Compare DUT against the model on the falling edge, then advance the model.
  always @(negedge clk) begin : cmp
    int g;
    bit ev;
    bit d_ok;
    int d;
    bit hs;
    bit rhs;
    bit inc;
    bit dec;
    logic [NB-1:0] e_rdy;
    logic [NB-1:0] e_rv;
    logic e_rr;
    x_issue_resp_t [NB-1:0] e_resp;
    x_issue_req_t e_req;

    if (rst_i) m_init = 1'b1;
    if (m_init) begin
      // who should be granted this cycle
      g  = -1;
      ev = 1'b0;
      if (!rst_i) begin
        if (m_locked) begin
          if (core_issue_valid_i[m_lock]) begin g = m_lock; ev = 1'b1; end
        end else begin
          for (int k = 0; k < NB; k++) begin
            int c;
            c = (m_ptr + k) % NB;
            if (!ev && core_issue_valid_i[c] && m_cnt[c] < MAXO) begin g = c; ev = 1'b1; end
          end
        end
      end
      e_rdy  = '0;
      e_resp = '0;
      e_req  = '0;
      if (ev) begin
        e_rdy[g]  = fpu_issue_ready_i;
        e_resp[g] = fpu_issue_resp_i;
        e_req     = core_issue_req_i[g];
      end
      d_ok = (fpu_dest_core_id_i < NB);
      d    = d_ok ? int'(fpu_dest_core_id_i) : -1;
      e_rv = '0;
      e_rr = 1'b0;
      if (!rst_i) begin
        if (d_ok) begin
          e_rv[d] = fpu_result_valid_i;
          e_rr    = core_result_ready_i[d];
        end else begin
          e_rr = 1'b1;
        end
      end

      chk("issue_valid", 64'(fpu_issue_valid_o), 64'(ev));
      chk("core_id", 64'(fpu_core_id_o), ev ? 64'(g) : 64'd0);
      chk("issue_req", 64'(fpu_issue_req_o), 64'(e_req));
      chk("core_ready", 64'(core_issue_ready_o), 64'(e_rdy));
      chk("core_resp", 64'(core_issue_resp_o), 64'(e_resp));
      chk("result_ready", 64'(fpu_result_ready_o), 64'(e_rr));
      chk("result_valid", 64'(core_result_valid_o), 64'(e_rv));
      chk("err", 64'(err_o), 64'(m_err));
      for (int i = 0; i < NB; i++) begin
        chk("outstanding", 64'(outstanding_o[i]), 64'(m_cnt[i]));
        chk("result_bcast", 64'(core_result_o[i]), 64'(fpu_result_i));
      end

      // advance the model to the post-edge state
      if (rst_i) begin
        for (int i = 0; i < NB; i++) m_cnt[i] = 0;
        m_locked = 1'b0; m_lock = 0; m_ptr = 0; m_err = 1'b0;
      end else begin
        hs  = ev && fpu_issue_ready_i;
        rhs = fpu_result_valid_i && e_rr;
        if (rhs && !d_ok) m_err = 1'b1;
        for (int i = 0; i < NB; i++) begin
          inc = hs && fpu_issue_resp_i.accept && (g == i);
          dec = rhs && d_ok && (d == i);
          if (inc && !dec) m_cnt[i] = m_cnt[i] + 1;
          else if (dec && !inc) begin
            if (m_cnt[i] == 0) m_err = 1'b1;
            else m_cnt[i] = m_cnt[i] - 1;
          end
        end
        if (m_locked) begin
          if (hs) begin m_locked = 1'b0; m_ptr = (m_lock + 1) % NB; end
          else if (!core_issue_valid_i[m_lock]) begin m_locked = 1'b0; m_err = 1'b1; end
        end else if (ev) begin
          if (hs) m_ptr = (g + 1) % NB;
          else begin m_locked = 1'b1; m_lock = g; end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_issue_valid_i = '0;
    for (int i = 0; i < NB; i++) begin
      core_issue_req_i[i].instr = $urandom;
      core_issue_req_i[i].id    = 4'($urandom);
    end
    fpu_issue_ready_i  = 1'b0;
    fpu_issue_resp_i   = '0;
    fpu_result_valid_i = 1'b0;
    fpu_result_i       = {4'($urandom), $urandom, 5'($urandom), 1'($urandom)};
    fpu_dest_core_id_i = 32'd0;
    core_result_ready_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  initial begin
    int seq1[3];
    int r;
    seq1 = '{0, 3, 5};

    // reset forces handshake signals low
    idle_inputs();
    rst_i = 1'b1;
    core_issue_valid_i  = '1;
    fpu_issue_ready_i   = 1'b1;
    fpu_result_valid_i  = 1'b1;
    core_result_ready_i = '1;
    #2;
    chk("rst_issue_valid", 64'(fpu_issue_valid_o), 64'd0);
    chk("rst_core_ready", 64'(core_issue_ready_o), 64'd0);
    chk("rst_result_ready", 64'(fpu_result_ready_o), 64'd0);
    chk("rst_result_valid", 64'(core_result_valid_o), 64'd0);
    cyc();
    cyc();
    rst_i = 1'b0;
    idle_inputs();
    #1;
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);

    // round-robin among cores 0,3,5 until each saturates at 4
    do_reset();
    core_issue_valid_i = 8'b0010_1001;
    fpu_issue_ready_i  = 1'b1;
    fpu_issue_resp_i   = '{accept: 1'b1, writeback: 1'b1, loadstore: 1'b0};
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("rr_grant", 64'(fpu_core_id_o), 64'(seq1[k % 3]));
      cyc();
    end
    #1;
    chk("rr_masked", 64'(fpu_issue_valid_o), 64'd0);
    chk("rr_cnt0", 64'(outstanding_o[0]), 64'd4);
    chk("rr_cnt3", 64'(outstanding_o[3]), 64'd4);
    chk("rr_cnt5", 64'(outstanding_o[5]), 64'd4);

    // stalled grant stays locked on core 2; core 6 waits
    do_reset();
    core_issue_valid_i = 8'b0100_0100;
    fpu_issue_resp_i   = '{accept: 1'b1, writeback: 1'b0, loadstore: 1'b0};
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lock_grant", 64'(fpu_core_id_o), 64'd2);
      chk("lock_ready", 64'(core_issue_ready_o), 64'd0);
      cyc();
    end
    fpu_issue_ready_i = 1'b1;
    #1;
    chk("lock_hs_grant", 64'(fpu_core_id_o), 64'd2);
    chk("lock_hs_ready", 64'(core_issue_ready_o), 64'h04);
    cyc();
    #1;
    chk("lock_next_grant", 64'(fpu_core_id_o), 64'd6);
    chk("lock_next_ready", 64'(core_issue_ready_o), 64'h40);

    // rejected issue does not count
    do_reset();
    core_issue_valid_i = 8'h02;
    fpu_issue_ready_i  = 1'b1;
    #1;
    chk("rej_ready", 64'(core_issue_ready_o), 64'h02);
    cyc();
    core_issue_valid_i = 8'h00;
    #1;
    chk("rej_cnt", 64'(outstanding_o[1]), 64'd0);
    core_issue_valid_i = 8'h02;
    fpu_issue_resp_i.accept = 1'b1;
    cyc();
    core_issue_valid_i = 8'h00;
    #1;
    chk("acc_cnt", 64'(outstanding_o[1]), 64'd1);

    // simultaneous issue and return, then saturation and drain
    do_reset();
    core_issue_valid_i = 8'h10;
    fpu_issue_ready_i  = 1'b1;
    fpu_issue_resp_i.accept = 1'b1;
    repeat (3) cyc();
    #1;
    chk("sim_cnt3", 64'(outstanding_o[4]), 64'd3);
    fpu_result_valid_i  = 1'b1;
    fpu_dest_core_id_i  = 32'd4;
    core_result_ready_i = 8'h10;
    #1;
    chk("sim_res_valid", 64'(core_result_valid_o), 64'h10);
    chk("sim_res_ready", 64'(fpu_result_ready_o), 64'd1);
    cyc();
    #1;
    chk("sim_cnt_hold", 64'(outstanding_o[4]), 64'd3);
    fpu_result_valid_i = 1'b0;
    cyc();
    #1;
    chk("sim_cnt4", 64'(outstanding_o[4]), 64'd4);
    chk("sim_masked", 64'(fpu_issue_valid_o), 64'd0);
    fpu_result_valid_i = 1'b1;
    cyc();
    fpu_result_valid_i = 1'b0;
    core_issue_valid_i = 8'h00;
    #1;
    chk("sim_drain", 64'(outstanding_o[4]), 64'd3);
    chk("sim_err", 64'(err_o), 64'd0);

    // out-of-range destination is sunk and flags a sticky error
    do_reset();
    fpu_result_valid_i  = 1'b1;
    fpu_dest_core_id_i  = 32'd9;
    core_result_ready_i = 8'hFF;
    #1;
    chk("bad_ready", 64'(fpu_result_ready_o), 64'd1);
    chk("bad_valid", 64'(core_result_valid_o), 64'd0);
    cyc();
    fpu_result_valid_i = 1'b0;
    fpu_dest_core_id_i = 32'd0;
    #1;
    chk("bad_err", 64'(err_o), 64'd1);
    repeat (3) cyc();
    #1;
    chk("bad_err_sticky", 64'(err_o), 64'd1);
    do_reset();
    #1;
    chk("bad_err_clr", 64'(err_o), 64'd0);

    // reset while locked on core 7 with a nonzero count
    do_reset();
    core_issue_valid_i = 8'h01;
    fpu_issue_ready_i  = 1'b1;
    fpu_issue_resp_i.accept = 1'b1;
    cyc();
    core_issue_valid_i = 8'h80;
    fpu_issue_ready_i  = 1'b0;
    #1;
    chk("mrst_grant7", 64'(fpu_core_id_o), 64'd7);
    cyc();
    core_issue_valid_i = 8'h81;
    #1;
    chk("mrst_locked7", 64'(fpu_core_id_o), 64'd7);
    chk("mrst_cnt0", 64'(outstanding_o[0]), 64'd1);
    cyc();
    rst_i = 1'b1;
    #1;
    chk("mrst_valid", 64'(fpu_issue_valid_o), 64'd0);
    cyc();
    rst_i = 1'b0;
    fpu_issue_ready_i = 1'b1;
    #1;
    chk("mrst_ptr0", 64'(fpu_core_id_o), 64'd0);
    chk("mrst_cnts", 64'(outstanding_o), 64'd0);
    chk("mrst_err", 64'(err_o), 64'd0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cyc();
      rst_i = ($urandom_range(0, 99) == 0);
      core_issue_valid_i = 8'($urandom) & 8'($urandom | $urandom);
      for (int i = 0; i < NB; i++) begin
        core_issue_req_i[i].instr = $urandom;
        core_issue_req_i[i].id    = 4'($urandom);
      end
      fpu_issue_ready_i  = ($urandom_range(0, 2) != 0);
      fpu_issue_resp_i   = '{accept: ($urandom_range(0, 3) != 0),
                             writeback: 1'($urandom), loadstore: 1'($urandom)};
      fpu_result_valid_i = 1'($urandom);
      fpu_result_i       = {4'($urandom), $urandom, 5'($urandom), 1'($urandom)};
      r = $urandom_range(0, 39);
      if (r < 37)      fpu_dest_core_id_i = 32'($urandom_range(0, NB - 1));
      else if (r < 39) fpu_dest_core_id_i = 32'($urandom_range(NB, 40));
      else             fpu_dest_core_id_i = $urandom;
      core_result_ready_i = 8'($urandom);
    end

    cyc();
    rst_i = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
